// File: rtl/uart_7n_pkg.sv
// Shared definitions for the 7N1 UART: frame geometry, sample points, FSM states
// and the baud divider calculation used by both receiver and transmitter.
package uart_7n_pkg;

    localparam int DATA_BITS = 7;
    localparam int OSR       = 16;

    typedef logic [3:0] os_t;

    localparam os_t SAMPLE_LO  = 4'd7;
    localparam os_t SAMPLE_MID = 4'd8;
    localparam os_t SAMPLE_HI  = 4'd9;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } state_t;

    // Clock cycles per oversample tick, rounded to nearest.
    function automatic int calc_div(input int clk_hz, input int baud);
        return (clk_hz + (baud * OSR) / 2) / (baud * OSR);
    endfunction

endpackage

// File: rtl/uart_rx_7n_if.sv
// Consumer-side bundle of the 7N1 receiver: byte handshake plus status strobes.
interface uart_rx_7n_if;
    import uart_7n_pkg::*;

    logic [DATA_BITS-1:0] data;
    logic                 valid;
    logic                 ready;
    logic                 frame_err;
    logic                 overrun;
    logic                 busy;

    modport master (output data, valid, frame_err, overrun, busy, input ready);
    modport slave  (input data, valid, frame_err, overrun, busy, output ready);

endinterface

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: one-cycle tick every DIV clocks, restartable by clr.
module uart_baud_tick #(
    parameter int DIV = 27
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    localparam int CW = $clog2(DIV);

    logic [CW-1:0] cnt;

    assign tick = (cnt == CW'(DIV - 1));

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/uart_rx_7n.sv
// 7N1 UART receiver: 16x oversampling with 3-sample majority vote and a
// single-entry valid/ready holding register towards the consumer.
module uart_rx_7n
    import uart_7n_pkg::*;
#(
    parameter int CLK_HZ = 50_142_857,
    parameter int BAUD   = 115_200
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         rx,
    uart_rx_7n_if.master bus
);

    localparam int DIV = calc_div(CLK_HZ, BAUD);

    logic                 rx_m, rx_s, rx_d;
    state_t               state, state_nxt;
    os_t                  os;
    logic [2:0]           idx;
    logic                 s_lo, s_mid;
    logic [DATA_BITS-1:0] shreg;
    logic                 tick, clr, fall, vote, vote_evt, wrap, last_bit;
    logic                 load, drop, bad_stop;

    // NOTE: synchroniser and edge flops reset to the idle-line level so reset release never fakes a start edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
            rx_d <= 1'b1;
        end else begin
            rx_m <= rx;
            rx_s <= rx_m;
            rx_d <= rx_s;
        end
    end

    assign fall     = rx_d & ~rx_s;
    assign vote_evt = tick && (os == SAMPLE_HI);
    assign vote     = (s_lo & s_mid) | (s_lo & rx_s) | (s_mid & rx_s);
    assign wrap     = tick && (os == os_t'(OSR - 1));
    assign last_bit = (idx == 3'(DATA_BITS - 1));

    uart_baud_tick #(.DIV(DIV)) u_tick (
        .clk  (clk),
        .rst  (rst),
        .clr  (clr),
        .tick (tick)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (fall) state_nxt = START;
            START:   if (vote_evt && vote) state_nxt = IDLE;
                     else if (wrap)        state_nxt = DATA;
            DATA:    if (wrap && last_bit) state_nxt = STOP;
            STOP:    if (vote_evt) state_nxt = vote ? IDLE : BREAK;
            BREAK:   if (rx_s) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.busy = (state != IDLE);
        clr      = (state == IDLE) && fall;
        load     = 1'b0;
        drop     = 1'b0;
        bad_stop = 1'b0;
        if (state == STOP && vote_evt) begin
            if (!vote)                       bad_stop = 1'b1;
            else if (!bus.valid || bus.ready) load    = 1'b1;
            else                              drop    = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            os    <= '0;
            idx   <= '0;
            s_lo  <= 1'b0;
            s_mid <= 1'b0;
            shreg <= '0;
        end else begin
            if (clr)       os <= '0;
            else if (tick) os <= os + 1'b1;

            if (tick && os == SAMPLE_LO)  s_lo  <= rx_s;
            if (tick && os == SAMPLE_MID) s_mid <= rx_s;

            if (state == START && wrap)                    idx <= '0;
            else if (state == DATA && wrap && !last_bit)   idx <= idx + 1'b1;

            if (state == DATA && vote_evt) shreg[idx] <= vote;
        end
    end

    // A load on the same cycle as a transfer keeps valid high with the new byte.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.data      <= '0;
            bus.valid     <= 1'b0;
            bus.frame_err <= 1'b0;
            bus.overrun   <= 1'b0;
        end else begin
            if (load) begin
                bus.data  <= shreg;
                bus.valid <= 1'b1;
            end else if (bus.valid && bus.ready) begin
                bus.valid <= 1'b0;
            end
            bus.frame_err <= bad_stop;
            bus.overrun   <= drop;
        end
    end

endmodule

// File: tb/tb_uart_rx_7n.sv
// Randomised bench for uart_rx_7n: serial frames against a holding-register model.
`timescale 1ns/1ps
module tb_uart_rx_7n;

    localparam int BIT_CLK = 432;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rx  = 1'b1;
    logic ready_lvl = 1'b0;

    uart_rx_7n_if bus();
    assign bus.ready = ready_lvl;

    uart_rx_7n dut (
        .clk (clk),
        .rst (rst),
        .rx  (rx),
        .bus (bus)
    );

    always #10 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Monitor: everything observed at the DUT boundary, sampled on the falling edge.
    int         cyc = 0;
    int         rise_cyc = 0;
    int         fe_cnt = 0;
    int         ov_cnt = 0;
    int         both_cnt = 0;
    logic       valid_q = 1'b0;
    logic [6:0] obs_q[$];

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (bus.valid === 1'b1 && valid_q !== 1'b1) rise_cyc <= cyc;
        valid_q <= bus.valid;
        if (bus.valid === 1'b1 && bus.ready === 1'b1) obs_q.push_back(bus.data);
        if (bus.frame_err === 1'b1) fe_cnt <= fe_cnt + 1;
        if (bus.overrun === 1'b1)   ov_cnt <= ov_cnt + 1;
        if (bus.frame_err === 1'b1 && bus.overrun === 1'b1) both_cnt <= both_cnt + 1;
    end

    // Reference model: what the consumer should see for each frame sent.
    logic [6:0] exp_q[$];
    int         exp_fe = 0;
    int         exp_ov = 0;
    bit         model_full = 1'b0;
    logic [6:0] model_hold = '0;

    task automatic model_frame(input logic [6:0] b, input bit stop_ok);
        if (!stop_ok)        exp_fe++;
        else if (ready_lvl)  exp_q.push_back(b);
        else if (model_full) exp_ov++;
        else begin
            model_full = 1'b1;
            model_hold = b;
        end
    endtask

    task automatic set_ready(input logic v);
        if (v && model_full) begin
            exp_q.push_back(model_hold);
            model_full = 1'b0;
        end
        ready_lvl = v;
    endtask

    task automatic drive_bit(input logic v, input int n);
        rx = v;
        repeat (n) @(posedge clk);
        #1;
    endtask

    int start_cyc = 0;

    task automatic send_frame(input logic [6:0] b, input bit stop_ok, input int bclk);
        start_cyc = cyc;
        drive_bit(1'b0, bclk);
        for (int i = 0; i < 7; i++) drive_bit(b[i], bclk);
        drive_bit(stop_ok, bclk);
        model_frame(b, stop_ok);
    endtask

    task automatic compare_beats(input string tag);
        int budget = 2000;
        while (obs_q.size() < exp_q.size() && budget > 0) begin
            @(posedge clk);
            budget--;
        end
        #1;
        check({tag, "_beats"}, obs_q.size(), exp_q.size());
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            check({tag, "_data"}, obs_q.pop_front(), exp_q.pop_front());
        end
        exp_q.delete();
        obs_q.delete();
        check({tag, "_frame_err"}, fe_cnt, exp_fe);
        check({tag, "_overrun"}, ov_cnt, exp_ov);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_data"},      bus.data,      0);
        check({tag, "_valid"},     bus.valid,     0);
        check({tag, "_frame_err"}, bus.frame_err, 0);
        check({tag, "_overrun"},   bus.overrun,   0);
        check({tag, "_busy"},      bus.busy,      0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check_reset_outputs("reset");
        drive_bit(1'b1, 20);
        set_ready(1'b1);

        // Single frame and start-to-valid latency.
        send_frame(7'h55, 1'b1, BIT_CLK);
        compare_beats("t1");
        check("t1_latency_window",
              (rise_cyc - start_cyc >= 3726) && (rise_cyc - start_cyc <= 3760), 1);

        // Back-to-back frames with no idle gap.
        send_frame(7'h00, 1'b1, BIT_CLK);
        send_frame(7'h7F, 1'b1, BIT_CLK);
        compare_beats("t2");

        // Short low glitch must be rejected as a false start.
        drive_bit(1'b0, 108);
        drive_bit(1'b1, 600);
        check("t3_busy_idle", bus.busy, 0);
        send_frame(7'h3C, 1'b1, BIT_CLK);
        compare_beats("t3");

        // Bad stop bit followed by a long break.
        send_frame(7'h2A, 1'b0, BIT_CLK);
        drive_bit(1'b0, 3 * BIT_CLK);
        drive_bit(1'b1, BIT_CLK);
        check("t4_valid_low", bus.valid, 0);
        send_frame(7'h11, 1'b1, BIT_CLK);
        compare_beats("t4");

        // Consumer stalled: second byte is dropped with an overrun pulse.
        set_ready(1'b0);
        send_frame(7'h12, 1'b1, BIT_CLK);
        drive_bit(1'b1, 100);
        send_frame(7'h34, 1'b1, BIT_CLK);
        drive_bit(1'b1, 100);
        check("t5_hold_data", bus.data, 7'h12);
        check("t5_hold_valid", bus.valid, 1);
        check("t5_overrun_seen", ov_cnt, exp_ov);
        set_ready(1'b1);
        drive_bit(1'b1, 2);
        check("t5_valid_falls", bus.valid, 0);
        compare_beats("t5");

        // Reset in the middle of data bit 3 loses the partial byte.
        begin
            logic [6:0] b = 7'h66;
            drive_bit(1'b0, BIT_CLK);
            for (int i = 0; i < 3; i++) drive_bit(b[i], BIT_CLK);
            drive_bit(b[3], BIT_CLK / 2);
        end
        check("t6_busy_before_rst", bus.busy, 1);
        rst = 1'b1;
        #1;
        check_reset_outputs("t6_rst");
        rx = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        drive_bit(1'b1, 50);
        check("t6_busy_after_rst", bus.busy, 0);
        send_frame(7'h19, 1'b1, BIT_CLK);
        compare_beats("t6");

        // Transmitter baud off by +/-2%.
        send_frame(7'h55, 1'b1, 441);
        drive_bit(1'b1, 20);
        send_frame(7'h55, 1'b1, 423);
        compare_beats("t7");

        // Random bytes, random idle gaps and random rate skew within 2%.
        for (int n = 0; n < 4; n++) begin
            logic [6:0] b = 7'($urandom_range(0, 127));
            int         bclk = int'($urandom_range(423, 441));
            drive_bit(1'b1, 1 + int'($urandom_range(0, 200)));
            send_frame(b, 1'b1, bclk);
        end
        compare_beats("rand");

        check("err_ovr_exclusive", both_cnt, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
